// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// The arbiter and its interface both import this package.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Returns the first set request at or above ptr, wrapping 7 -> 0.
  // The loop walks downward so that the smallest offset from ptr is written last.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            p;
    logic [IDX_W-1:0] c;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      c = ptr + IDX_W'(i);
      if (req[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arb8_ctrl_if.sv
// Request/grant bundle between the requesting agents (master side)
// and the arbiter (slave side).
interface rr_arb8_ctrl_if;
  import rr_arb_pkg::*;

  logic                    en;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_vld;
  logic                    busy;

  modport master (output en, req, input gnt, gnt_idx, gnt_vld, busy);
  modport slave  (input en, req, output gnt, gnt_idx, gnt_vld, busy);
endinterface

// File: rtl/rr_arb8_ctrl_dec38_en.sv
// 3-to-8 one-hot decoder with active-high enable.
// The output is all-zero when e is low.
module dec38_en (
  input  logic [2:0] d,
  input  logic       e,
  output logic [7:0] y
);

  assign y = e ? (8'b0000_0001 << d) : 8'b0000_0000;

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter/sequencer for one 8-way select resource: bounded hold,
// one-cycle turnaround gap, and a decoded one-hot grant taken only from registers.
module rr_arb8_ctrl
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arb8_ctrl_if.slave  bus
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = '1;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] gnt_idx, gnt_idx_nxt;
  logic             gnt_vld, gnt_vld_nxt;
  logic [HW-1:0]    hold_cnt, hold_cnt_nxt;
  pick_t            pick;
  logic             timeout;

  assign pick    = rr_pick(bus.req, ptr);
  assign timeout = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  // NOTE: every signal written here gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gnt_idx_nxt  = gnt_idx;
    gnt_vld_nxt  = gnt_vld;
    hold_cnt_nxt = hold_cnt;

    case (state)
      IDLE: begin
        if (bus.en && pick.found) begin
          state_nxt    = GRANT;
          gnt_idx_nxt  = pick.idx;
          gnt_vld_nxt  = 1'b1;
          hold_cnt_nxt = '0;
        end
      end

      GRANT: begin
        if (hold_cnt != HOLD_MAX) hold_cnt_nxt = hold_cnt + HW'(1);
        // Release and timeout both move on, and both advance ptr past the owner.
        if (!bus.req[gnt_idx] || timeout) begin
          state_nxt   = GAP;
          gnt_vld_nxt = 1'b0;
          ptr_nxt     = gnt_idx + IDX_W'(1);
        end
      end

      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= gnt_idx_nxt;
      gnt_vld  <= gnt_vld_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  assign bus.gnt_idx = gnt_idx;
  assign bus.gnt_vld = gnt_vld;
  assign bus.busy    = (state != IDLE);

  dec38_en u_dec (
    .d (gnt_idx),
    .e (gnt_vld),
    .y (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Randomized and directed bench for rr_arb8_ctrl: a cycle-level reference model
// queues expected outputs, and a monitor compares them on the falling edge.
module tb_rr_arb8_ctrl;

  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst_n;

  rr_arb8_ctrl_if bus ();

  rr_arb8_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner is -1 when nobody holds the resource.
  initial begin : model
    int   owner;
    int   held;
    bit   gap;
    int   next_ptr;
    int   last;
    exp_t e;
    owner = -1; held = 0; gap = 0; next_ptr = 0; last = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        owner = -1; held = 0; gap = 0; next_ptr = 0; last = 0;
        exp_q.delete();
      end else begin
        if (owner >= 0) begin
          held++;
          if (!bus.req[owner] || (MAX_HOLD != 0 && held >= MAX_HOLD)) begin
            next_ptr = (owner + 1) % 8;
            owner    = -1;
            gap      = 1;
          end
        end else if (gap) begin
          gap = 0;
        end else if (bus.en && bus.req != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            if (owner < 0 && bus.req[(next_ptr + k) % 8]) owner = (next_ptr + k) % 8;
          end
          held = 0;
          last = owner;
        end
        e.gnt  = (owner >= 0) ? (8'h01 << owner) : 8'h00;
        e.idx  = 3'(last);
        e.vld  = (owner >= 0);
        e.busy = (owner >= 0) || gap;
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",     32'(bus.gnt),     32'(e.gnt));
        check("gnt_idx", 32'(bus.gnt_idx), 32'(e.idx));
        check("gnt_vld", 32'(bus.gnt_vld), 32'(e.vld));
        check("busy",    32'(bus.busy),    32'(e.busy));
        check("onehot",  32'($onehot0(bus.gnt)), 32'(1));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    #2;
    check("rst_gnt",  32'(bus.gnt),     32'h0);
    check("rst_vld",  32'(bus.gnt_vld), 32'h0);
    check("rst_busy", 32'(bus.busy),    32'h0);
    check("rst_idx",  32'(bus.gnt_idx), 32'h0);
    cyc(3);
    rst_n = 1'b1;

    bus.en = 1'b1;
    cyc(6);

    // Single requester at index 4, then a lower+higher pair.
    bus.req = 8'h10; cyc(3);
    bus.req = 8'h00; cyc(3);
    bus.req = 8'h84; cyc(12);
    bus.req = 8'h00; cyc(4);

    // Full load: strict rotation with timeouts.
    bus.req = 8'hFF; cyc(60);
    bus.req = 8'h00; cyc(4);

    // Grant index 5 so the pointer sits at 6, then wrap to 0 and 1.
    bus.req = 8'h20; cyc(2);
    bus.req = 8'h00; cyc(4);
    bus.req = 8'h03; cyc(16);
    bus.req = 8'h00; cyc(4);

    // Sole requester repeatedly timing out.
    bus.req = 8'h01; cyc(24);
    bus.req = 8'h00; cyc(4);

    // Enable gating.
    bus.en = 1'b0; bus.req = 8'h0C; cyc(5);
    bus.en = 1'b1; cyc(2);
    bus.en = 1'b0; cyc(3);
    bus.req = 8'h08; cyc(6);
    bus.en = 1'b1; cyc(8);
    bus.req = 8'h00; cyc(4);

    // Asynchronous reset in the middle of a grant.
    bus.req = 8'h40; cyc(2);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt",  32'(bus.gnt),     32'h0);
    check("midrst_vld",  32'(bus.gnt_vld), 32'h0);
    check("midrst_busy", 32'(bus.busy),    32'h0);
    check("midrst_idx",  32'(bus.gnt_idx), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);

    // Random traffic with slowly changing requests and mostly-on enable.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) bus.req = 8'($urandom);
      if ($urandom_range(9) == 0) bus.req = 8'h00;
      bus.en = ($urandom_range(7) != 0);
      cyc(1);
    end
    bus.req = 8'h00;
    cyc(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
